// File: rtl/hazard_pkg.sv
// Shared constants for the hazard controller: FSM encoding, default
// register-specifier width and the performance-counter width.
package hazard_pkg;
  localparam int REG_W_DEF = 4;
  localparam int CNT_W     = 16;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2,
    ST_BAD   = 2'd3
  } hz_state_e;
endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle.
// master: pipeline side (drives hazard sources, consumes controls).
// slave : hazard controller.
interface hazard_ctrl_if import hazard_pkg::*; #(
  parameter int REG_W = REG_W_DEF
);
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rt;
  logic             idex_memread;
  logic [REG_W-1:0] idex_rd;
  logic             br_taken;
  logic             mem_wait;
  logic             halt_req;
  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             halted;
  logic [1:0]       state;

  modport master (
    output id_rs, id_rt, id_uses_rt, idex_memread, idex_rd, br_taken, mem_wait, halt_req,
    input  pc_en, ifid_en, ifid_flush, idex_flush, halted, state
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, idex_memread, idex_rd, br_taken, mem_wait, halt_req,
    output pc_en, ifid_en, ifid_flush, idex_flush, halted, state
  );
endinterface

// File: rtl/sat_cnt16.sv
// Saturating event counter: synchronous clear wins over increment,
// sticks at all-ones instead of wrapping.
module sat_cnt16 import hazard_pkg::*; (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  logic [CNT_W-1:0] cnt_q;

  // count up on inc until full, clear on clr
  always_ff @(posedge clk) begin
    if (clr)                       cnt_q <= '0;
    else if (inc && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: freeze on mem_wait, squash after taken
// branches, one-cycle load-use bubble, sticky HALT until reset.
// Optional build macro HAZARD_PERF_CNT_EN adds stall_cnt / flush_cnt.
module hazard_ctrl import hazard_pkg::*; #(
  parameter int REG_W    = REG_W_DEF,
  parameter int BR_FLUSH = 2
) (
  input  logic             clk,
  input  logic             rst,
  hazard_ctrl_if.slave     hz
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);
  localparam logic [REG_W-1:0] RD_ZERO      = '0;
  // count of flush cycles still owed after the branch cycle itself
  localparam logic [2:0]       FLUSH_RELOAD = 3'(BR_FLUSH - 1);

  hz_state_e  state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       load_use;
  logic       pc_en, ifid_en, ifid_flush, idex_flush, halted;

  assign load_use = hz.idex_memread && (hz.idex_rd != RD_ZERO) &&
                    ((hz.idex_rd == hz.id_rs) || (hz.id_uses_rt && (hz.idex_rd == hz.id_rt)));

  // state and remaining-flush register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // next state: freeze > branch > flush countdown > halt
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN, ST_FLUSH: begin
        if (hz.mem_wait) begin
          state_d = state_q;
        end else if (hz.br_taken) begin
          if (BR_FLUSH == 1) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            state_d = ST_FLUSH;
            cnt_d   = FLUSH_RELOAD;
          end
        end else if (state_q == ST_FLUSH) begin
          // halt_req is ignored here: that instruction is being squashed
          if (cnt_q <= 3'd1) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d   = cnt_q - 3'd1;
          end
        end else if (hz.halt_req) begin
          state_d = ST_HALT;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // pipeline controls, combinational from state and inputs
  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    halted     = 1'b0;
    if (rst) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else begin
      case (state_q)
        ST_HALT: begin
          pc_en   = 1'b0;
          ifid_en = 1'b0;
          halted  = 1'b1;
        end
        ST_RUN, ST_FLUSH: begin
          if (hz.mem_wait) begin
            pc_en   = 1'b0;
            ifid_en = 1'b0;
          end else if (hz.br_taken || (state_q == ST_FLUSH)) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (!hz.halt_req && load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign hz.pc_en      = pc_en;
  assign hz.ifid_en    = ifid_en;
  assign hz.ifid_flush = ifid_flush;
  assign hz.idex_flush = idex_flush;
  assign hz.halted     = halted;
  assign hz.state      = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic active, stall_inc, flush_inc;

  assign active    = (state_q == ST_RUN) || (state_q == ST_FLUSH);
  assign stall_inc = !rst && !pc_en && (state_q != ST_HALT);
  assign flush_inc = !rst && active && !hz.mem_wait && hz.br_taken;

  sat_cnt16 u_stall_cnt (.clk(clk), .clr(rst), .inc(stall_inc), .cnt(stall_cnt));
  sat_cnt16 u_flush_cnt (.clk(clk), .clr(rst), .inc(flush_inc), .cnt(flush_cnt));
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized + directed bench for hazard_ctrl against a cycle-level
// behavioural model (halted flag, owed-flush count, event tallies).
module tb_hazard_ctrl;
  import hazard_pkg::*;

  localparam int BRF = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.REG_W(4)) hz();
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cnt, flush_cnt;
`endif

  hazard_ctrl #(.REG_W(4), .BR_FLUSH(BRF)) dut (
    .clk(clk),
    .rst(rst),
    .hz(hz)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // model: sticky halt, number of flush cycles still owed, event tallies
  bit m_halted = 1'b0;
  int m_left   = 0;
  int m_stall  = 0;
  int m_flush  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // one clock cycle: drive, check combinational outputs, advance model
  task automatic cyc(input bit r, input bit mw, input bit br, input bit hr,
                     input bit mr, input logic [3:0] rd, input logic [3:0] rs,
                     input logic [3:0] rt, input bit ut);
    bit lu;
    bit e_pc, e_ife, e_iff, e_idf, e_h;
    int e_st;
    rst = r;
    hz.mem_wait = mw; hz.br_taken = br; hz.halt_req = hr;
    hz.idex_memread = mr; hz.idex_rd = rd; hz.id_rs = rs; hz.id_rt = rt; hz.id_uses_rt = ut;
    #3;
    lu = mr && (rd != 0) && ((rd == rs) || (ut && (rd == rt)));
    e_pc = 1; e_ife = 1; e_iff = 0; e_idf = 0; e_h = 0;
    if (r)                    begin e_iff = 1; e_idf = 1; end
    else if (m_halted)        begin e_pc = 0; e_ife = 0; e_h = 1; end
    else if (mw)              begin e_pc = 0; e_ife = 0; end
    else if (br || m_left > 0) begin e_iff = 1; e_idf = 1; end
    else if (hr)              begin end
    else if (lu)              begin e_pc = 0; e_ife = 0; e_idf = 1; end
    e_st = m_halted ? 2 : (m_left > 0 ? 1 : 0);
    chk("pc_en",      hz.pc_en,      e_pc);
    chk("ifid_en",    hz.ifid_en,    e_ife);
    chk("ifid_flush", hz.ifid_flush, e_iff);
    chk("idex_flush", hz.idex_flush, e_idf);
    chk("halted",     hz.halted,     e_h);
    chk("state",      hz.state,      e_st);
    @(posedge clk);
    if (r) begin
      m_halted = 0; m_left = 0; m_stall = 0; m_flush = 0;
    end else if (m_halted) begin
    end else if (mw) begin
      if (m_stall < 16'hFFFF) m_stall++;
    end else if (br) begin
      m_left = BRF - 1;
      if (m_flush < 16'hFFFF) m_flush++;
    end else if (m_left > 0) begin
      m_left--;
    end else if (hr) begin
      m_halted = 1;
    end else if (lu) begin
      if (m_stall < 16'hFFFF) m_stall++;
    end
    #1;
`ifdef HAZARD_PERF_CNT_EN
    chk("stall_cnt", stall_cnt, m_stall);
    chk("flush_cnt", flush_cnt, m_flush);
`endif
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0);
  endtask

  initial begin
    bit r, mw, br, hr, mr, ut;
    // reset state
    cyc(1, 0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0);
    cyc(1, 1, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0);
    idle();
    // load-use on rs, one cycle only
    cyc(0, 0, 0, 0, 1, 4'd3, 4'd3, 4'd0, 0);
    idle();
    // load-use on rt, and rt not used
    cyc(0, 0, 0, 0, 1, 4'd5, 4'd1, 4'd5, 1);
    cyc(0, 0, 0, 0, 1, 4'd5, 4'd1, 4'd5, 0);
    // r0 destination never stalls
    cyc(0, 0, 0, 0, 1, 4'd0, 4'd0, 4'd0, 1);
    // branch pulse: two flush cycles then RUN
    cyc(0, 0, 1, 0, 0, 4'd0, 4'd0, 4'd0, 0);
    idle(); idle();
    // branch + halt together, halt during flush ignored
    cyc(0, 0, 1, 1, 0, 4'd0, 4'd0, 4'd0, 0);
    cyc(0, 0, 0, 1, 0, 4'd0, 4'd0, 4'd0, 0);
    idle(); idle();
    // mem_wait held 3 cycles mid-flush
    cyc(0, 0, 1, 0, 0, 4'd0, 4'd0, 4'd0, 0);
    repeat (3) cyc(0, 1, 0, 0, 1, 4'd2, 4'd2, 4'd0, 0);
    idle(); idle();
    // halt, then inputs toggling, then reset
    cyc(0, 0, 0, 1, 0, 4'd0, 4'd0, 4'd0, 0);
    cyc(0, 1, 1, 0, 1, 4'd2, 4'd2, 4'd2, 1);
    cyc(0, 0, 1, 1, 1, 4'd3, 4'd3, 4'd0, 0);
    cyc(1, 0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0);
    idle();
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 99) < 2) || (m_halted && ($urandom_range(0, 7) == 0));
      mw = ($urandom_range(0, 99) < 15);
      br = ($urandom_range(0, 99) < 10);
      hr = ($urandom_range(0, 99) < 4);
      mr = ($urandom_range(0, 99) < 40);
      ut = $urandom_range(0, 1);
      cyc(r, mw, br, hr, mr, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
          4'($urandom_range(0, 3)), ut);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_W, default 4, register-specifier width.
REQ-002 SHALL have parameter BR_FLUSH, default 2, total flush cycles per taken branch, legal range 1..7.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have ports id_rs and id_rt, input, REG_W each, source specifiers of the instruction in IF/ID.
REQ-006 SHALL have port id_uses_rt, input, 1, high when the ID instruction reads rt.
REQ-007 SHALL have ports idex_memread (input, 1) and idex_rd (input, REG_W), the load flag and destination of the instruction in ID/EX.
REQ-008 SHALL have port br_taken, input, 1, taken branch/jump resolved in EX.
REQ-009 SHALL have port mem_wait, input, 1, data memory not ready, freeze pipeline.
REQ-010 SHALL have port halt_req, input, 1, HLT decoded in ID.
REQ-011 SHALL have outputs pc_en, ifid_en, ifid_flush, idex_flush, 1 bit each, plus halted (1 bit) and state (2 bits).

Function
REQ-012 SHALL implement FSM states RUN=0, FLUSH=1, HALT=2; encoding 3 unused and recovers to RUN on the next edge.
REQ-013 Per-cycle priority SHALL be: mem_wait > br_taken > halt_req > load-use > normal.
REQ-014 mem_wait=1: pc_en=0, ifid_en=0, both flushes 0, FSM and flush counter hold (freeze).
REQ-015 br_taken=1 (no mem_wait, state RUN or FLUSH): pc_en=1, ifid_en=1, ifid_flush=1, idex_flush=1; next state FLUSH with remaining count BR_FLUSH-1, or RUN if BR_FLUSH=1.
REQ-016 In FLUSH: ifid_flush=1, idex_flush=1, pc_en=ifid_en=1; counter decrements each unfrozen cycle; return to RUN when it reaches 0; a new br_taken reloads the count.
REQ-017 Load-use hazard = idex_memread & (idex_rd!=0) & (idex_rd==id_rs | (id_uses_rt & idex_rd==id_rt)); valid only in RUN.
REQ-018 Load-use in RUN: pc_en=0, ifid_en=0, idex_flush=1, ifid_flush=0; lasts exactly one cycle per hazard; state stays RUN.
REQ-019 halt_req in RUN with no higher-priority event: next state HALT; the request cycle itself behaves as normal.
REQ-020 In HALT: pc_en=0, ifid_en=0, flushes 0, halted=1; all inputs ignored until rst.
REQ-021 halt_req SHALL be ignored while in FLUSH (instruction is being squashed).
REQ-022 Normal RUN: pc_en=1, ifid_en=1, flushes 0.
REQ-023 Control outputs SHALL be combinational from state and inputs; only state, flush counter and counters are registered.

Reset
REQ-024 rst=1 on an edge SHALL force state RUN, flush counter 0, counters 0, regardless of mem_wait or HALT.
REQ-025 While rst is high, outputs SHALL be pc_en=1, ifid_en=1, ifid_flush=1, idex_flush=1, halted=0.

Configuration
REQ-026 With HAZARD_PERF_CNT_EN defined: 16-bit outputs stall_cnt (cycles with pc_en=0 outside HALT) and flush_cnt (br_taken events accepted), each saturating at 0xFFFF.
REQ-027 Without HAZARD_PERF_CNT_EN: those ports and registers SHALL be absent; all other behaviour is identical.

Structure
REQ-028 Package hazard_pkg SHALL hold state encodings, REG_W default and the 16-bit counter width constant.
REQ-029 The saturating counter SHALL be one sub-module sat_cnt16 (inc, clr), instanced twice under the macro.

Verification
REQ-030 Load-use: idex_memread=1, idex_rd=3, id_rs=3 for 1 cycle -> pc_en=0, ifid_en=0, idex_flush=1 that cycle only; stall_cnt=1.
REQ-031 idex_rd=0 with id_rs=0, idex_memread=1 -> no stall, pc_en=1.
REQ-032 br_taken pulse, BR_FLUSH=2 -> ifid_flush=1 for 2 cycles, state RUN on 3rd; flush_cnt=1.
REQ-033 br_taken and halt_req same cycle -> FLUSH entered, never HALT; halt_req during FLUSH ignored.
REQ-034 mem_wait held 3 cycles mid-FLUSH -> outputs frozen, flush resumes with same remaining count; stall_cnt +3.
REQ-035 halt_req in RUN -> halted=1 next cycle, stays with inputs toggling; rst -> RUN, counters 0.
